// File: rtl/restoring_divider.sv
// restoring_divider: 8-bit sequential restoring divider, one quotient bit per ITER cycle.
// Define DIVIDER_SIGNED_EN for two's-complement operands (magnitude in LOAD, sign fix in FIX).
module restoring_divider (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       ClearA_LoadB,
    input  logic       Run,
    input  logic [7:0] Din,
    output logic [7:0] Aval,
    output logic [7:0] Bval,
    output logic       DivZero,
    output logic       Busy
);
`ifdef DIVIDER_SIGNED_EN
    localparam bit SGN = 1'b1;
`else
    localparam bit SGN = 1'b0;
`endif
    typedef enum logic [2:0] {IDLE, LOAD, ITER, FIX, HOLD} state_t;
    state_t state, state_nx;
    logic [7:0] a, b, d, a_nx, b_nx, d_nx;
    logic [2:0] cnt, cnt_nx;
    logic dz, dz_nx, sb, sd, sb_nx, sd_nx;
    logic [15:0] t;
    logic [8:0] diff;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
            a     <= '0;
            b     <= '0;
            d     <= '0;
            cnt   <= '0;
            dz    <= 1'b0;
            sb    <= 1'b0;
            sd    <= 1'b0;
        end else begin
            state <= state_nx;
            a     <= a_nx;
            b     <= b_nx;
            d     <= d_nx;
            cnt   <= cnt_nx;
            dz    <= dz_nx;
            sb    <= sb_nx;
            sd    <= sd_nx;
        end
    end

    always_comb begin
        state_nx = state;
        a_nx     = a;
        b_nx     = b;
        d_nx     = d;
        cnt_nx   = cnt;
        dz_nx    = dz;
        sb_nx    = sb;
        sd_nx    = sd;
        t        = {a, b} << 1;
        diff     = {1'b0, t[15:8]} - {1'b0, d};
        case (state)
            IDLE: begin
                if (ClearA_LoadB) begin
                    b_nx  = Din;
                    a_nx  = '0;
                    dz_nx = 1'b0;
                end else if (Run) begin
                    d_nx     = Din;
                    state_nx = LOAD;
                end
            end
            LOAD: begin
                if (d == '0) begin
                    b_nx     = 8'hFF;
                    dz_nx    = 1'b1;
                    state_nx = HOLD;
                end else begin
                    // original signs are kept for the correction step in FIX
                    sb_nx    = SGN & b[7];
                    sd_nx    = SGN & d[7];
                    a_nx     = '0;
                    b_nx     = (SGN && b[7]) ? 8'd0 - b : b;
                    d_nx     = (SGN && d[7]) ? 8'd0 - d : d;
                    dz_nx    = 1'b0;
                    cnt_nx   = '0;
                    state_nx = ITER;
                end
            end
            ITER: begin
                a_nx     = diff[8] ? t[15:8] : diff[7:0];
                b_nx     = {t[7:1], ~diff[8]};
                cnt_nx   = (cnt == 3'd7) ? cnt : cnt + 3'd1;
                state_nx = (cnt == 3'd7) ? FIX : ITER;
            end
            FIX: begin
                b_nx     = (sb ^ sd) ? 8'd0 - b : b;
                a_nx     = sb ? 8'd0 - a : a;
                state_nx = HOLD;
            end
            HOLD: state_nx = Run ? HOLD : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign Aval    = a;
    assign Bval    = b;
    assign DivZero = dz;
    assign Busy    = (state != IDLE);
endmodule
